// File: rtl/taillight_sequencer.sv
// Purpose: arbitrates left/right/hazard/brake onto the six rear lamps and runs prescaled sweep animations.
// Latency: lamps, busy and mode are registered decodes of the next state, so they change on the same edge as the state.
// Backpressure: none; requests are level-sensitive and sampled every cycle, and turn changes mid-sweep are ignored.
module taillight_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       brake,
    output logic       LC,
    output logic       LB,
    output logic       LA,
    output logic       RA,
    output logic       RB,
    output logic       RC,
    output logic       busy,
    output logic [1:0] mode
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_L1     = 4'd1;
    localparam logic [3:0] S_L2     = 4'd2;
    localparam logic [3:0] S_L3     = 4'd3;
    localparam logic [3:0] S_R1     = 4'd4;
    localparam logic [3:0] S_R2     = 4'd5;
    localparam logic [3:0] S_R3     = 4'd6;
    localparam logic [3:0] S_HZ_ON  = 4'd7;
    localparam logic [3:0] S_HZ_OFF = 4'd8;

    logic [3:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    w_pick;
    logic [3:0]    w_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_tick;
    logic [5:0]    w_lamps;   // {LC, LB, LA, RA, RB, RC}
    logic          w_busy;
    logic [1:0]    w_mode;
    logic [5:0]    r_lamps;
    logic          r_busy;
    logic [1:0]    r_mode;

    assign w_tick = (r_cnt == TICK_LAST);

    // Request arbitration: hazard (or both turns) beats left beats right.
    always_comb begin
        w_pick = S_IDLE;
        if (hazard || (left && right)) begin
            w_pick = S_HZ_ON;
        end else if (left) begin
            w_pick = S_L1;
        end else if (right) begin
            w_pick = S_R1;
        end
    end

    // Next-state: sweeps step on tick, hazard preempts any turn sweep, sweep ends re-arbitrate.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_pick;
            S_L1:     w_next = hazard ? S_HZ_ON : (w_tick ? S_L2 : S_L1);
            S_L2:     w_next = hazard ? S_HZ_ON : (w_tick ? S_L3 : S_L2);
            S_L3:     w_next = hazard ? S_HZ_ON : (w_tick ? w_pick : S_L3);
            S_R1:     w_next = hazard ? S_HZ_ON : (w_tick ? S_R2 : S_R1);
            S_R2:     w_next = hazard ? S_HZ_ON : (w_tick ? S_R3 : S_R2);
            S_R3:     w_next = hazard ? S_HZ_ON : (w_tick ? w_pick : S_R3);
            S_HZ_ON:  w_next = w_tick ? S_HZ_OFF : S_HZ_ON;
            S_HZ_OFF: w_next = w_tick ? w_pick : S_HZ_OFF;
            default:  w_next = S_IDLE;
        endcase
    end

    // Prescaler restarts on every state change and stays parked at 0 while idle.
    always_comb begin
        w_cnt_next = '0;
        if ((w_next == r_state) && (r_state != S_IDLE) && !w_tick) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Output decode of the upcoming state, with brake lighting whichever side is not animating.
    always_comb begin
        w_lamps = 6'b000000;
        w_busy  = (w_next != S_IDLE);
        w_mode  = 2'b00;
        case (w_next)
            S_IDLE:   w_lamps = brake ? 6'b111111 : 6'b000000;
            S_L1:     w_lamps = {3'b001, {3{brake}}};
            S_L2:     w_lamps = {3'b011, {3{brake}}};
            S_L3:     w_lamps = {3'b111, {3{brake}}};
            S_R1:     w_lamps = {{3{brake}}, 3'b100};
            S_R2:     w_lamps = {{3{brake}}, 3'b110};
            S_R3:     w_lamps = {{3{brake}}, 3'b111};
            S_HZ_ON:  w_lamps = 6'b111111;
            S_HZ_OFF: w_lamps = 6'b000000;
            default:  w_lamps = 6'b000000;
        endcase
        if ((w_next >= S_L1) && (w_next <= S_L3)) begin
            w_mode = 2'b01;
        end else if ((w_next >= S_R1) && (w_next <= S_R3)) begin
            w_mode = 2'b10;
        end else if ((w_next == S_HZ_ON) || (w_next == S_HZ_OFF)) begin
            w_mode = 2'b11;
        end
    end

    // State, prescaler and registered outputs; reset abandons any sweep and darkens the bank at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lamps <= 6'b000000;
            r_busy  <= 1'b0;
            r_mode  <= 2'b00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_lamps <= w_lamps;
            r_busy  <= w_busy;
            r_mode  <= w_mode;
        end
    end

    assign {LC, LB, LA, RA, RB, RC} = r_lamps;
    assign busy = r_busy;
    assign mode = r_mode;

endmodule

// File: tb/tb_taillight_sequencer.sv
module tb_taillight_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       l_in = 1'b0, r_in = 1'b0, h_in = 1'b0, b_in = 1'b0;
    logic       LC, LB, LA, RA, RB, RC, busy;
    logic [1:0] mode;
    logic [5:0] lamps;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: which animation is running and how many cycles since it began.
    int         m_anim = 0;   // 0 none, 1 left, 2 right, 3 hazard
    int         m_age  = 0;
    logic [5:0] m_lamps = '0;
    logic       m_busy = 1'b0;
    logic [1:0] m_mode = 2'b00;

    typedef struct {
        logic l, r, h, b;
        logic [5:0] lamps;
        logic busy;
        logic [1:0] mode;
    } vec_t;
    vec_t tbl[15];

    taillight_sequencer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(rst), .left(l_in), .right(r_in), .hazard(h_in), .brake(b_in),
        .LC(LC), .LB(LB), .LA(LA), .RA(RA), .RB(RB), .RC(RC), .busy(busy), .mode(mode)
    );

    assign lamps = {LC, LB, LA, RA, RB, RC};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_anim = 0; m_age = 0; m_lamps = '0; m_busy = 1'b0; m_mode = 2'b00;
    endtask

    task automatic model_edge(input logic l, input logic r, input logic h, input logic b);
        int p;
        int n;
        p = (h || (l && r)) ? 3 : (l ? 1 : (r ? 2 : 0));
        if (m_anim == 0) begin
            m_anim = p; m_age = 0;
        end else if ((m_anim == 1 || m_anim == 2) && h) begin
            m_anim = 3; m_age = 0;
        end else begin
            m_age++;
            if (m_age == ((m_anim == 3) ? 2 * TD : 3 * TD)) begin
                m_anim = p; m_age = 0;
            end
        end
        n = m_age / TD;
        m_lamps = '0;
        case (m_anim)
            0: m_lamps = b ? 6'h3F : 6'h00;
            1: begin
                m_lamps[3] = 1'b1; m_lamps[4] = (n >= 1); m_lamps[5] = (n >= 2);
                if (b) m_lamps[2:0] = 3'b111;
            end
            2: begin
                m_lamps[2] = 1'b1; m_lamps[1] = (n >= 1); m_lamps[0] = (n >= 2);
                if (b) m_lamps[5:3] = 3'b111;
            end
            default: m_lamps = (m_age < TD) ? 6'h3F : 6'h00;
        endcase
        m_busy = (m_anim != 0);
        m_mode = 2'(m_anim);
    endtask

    // Apply one cycle of inputs, advance the model, compare just after the edge.
    task automatic step(input logic l, input logic r, input logic h, input logic b);
        l_in = l; r_in = r; h_in = h; b_in = b;
        @(posedge clk);
        model_edge(l, r, h, b);
        #1;
        chk("model_lamps", {2'b00, lamps}, {2'b00, m_lamps});
        chk("model_busy", {7'd0, busy}, {7'd0, m_busy});
        chk("model_mode", {6'd0, mode}, {6'd0, m_mode});
    endtask

    // Pulse reset between edges and confirm outputs clear without a clock edge.
    task automatic mid_reset(input string name);
        #3 rst = 1'b1;
        #1;
        chk({name, "_lamps"}, {2'b00, lamps}, 8'h00);
        chk({name, "_busy"}, {7'd0, busy}, 8'h00);
        chk({name, "_mode"}, {6'd0, mode}, 8'h00);
        model_reset();
        #1 rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic l, input logic r, input logic h, input logic b,
                           input logic [5:0] lp, input logic bs, input logic [1:0] md);
        tbl[i].l = l; tbl[i].r = r; tbl[i].h = h; tbl[i].b = b;
        tbl[i].lamps = lp; tbl[i].busy = bs; tbl[i].mode = md;
    endtask

    initial begin
        // Single left sweep (left dropped at k+5), then brake alone, then brake with right.
        for (int i = 0; i < 15; i++) begin
            if (i < 4)        set_vec(i, i < 5, 0, 0, 0, 6'o10, 1, 2'b01);
            else if (i < 8)   set_vec(i, i < 5, 0, 0, 0, 6'o30, 1, 2'b01);
            else if (i < 12)  set_vec(i, 0, 0, 0, 0, 6'o70, 1, 2'b01);
            else if (i == 12) set_vec(i, 0, 0, 0, 0, 6'o00, 0, 2'b00);
            else if (i == 13) set_vec(i, 0, 0, 0, 1, 6'o77, 0, 2'b00);
            else              set_vec(i, 0, 1, 0, 1, 6'o74, 1, 2'b10);
        end

        // Reset and idle.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lamps", {2'b00, lamps}, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        model_reset();
        repeat (3) step(0, 0, 0, 0);
        chk("idle_mode", {6'd0, mode}, 8'h00);

        // Table-driven left sweep and brake overlay.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].l, tbl[i].r, tbl[i].h, tbl[i].b);
            chk("tbl_lamps", {2'b00, lamps}, {2'b00, tbl[i].lamps});
            chk("tbl_busy", {7'd0, busy}, {7'd0, tbl[i].busy});
            chk("tbl_mode", {6'd0, mode}, {6'd0, tbl[i].mode});
        end

        // Held right with brake: repeat of the right sweep with left side steady on.
        mid_reset("rst_a");
        for (int i = 0; i < 13; i++) begin
            step(0, 1, 0, 1);
            chk("hold_right_lamps", {2'b00, lamps},
                (i < 4) ? 8'o74 : (i < 8) ? 8'o76 : (i < 12) ? 8'o77 : 8'o74);
            chk("hold_right_mode", {6'd0, mode}, 8'd2);
        end

        // Hazard preemption during L2 at cnt=1.
        mid_reset("rst_b");
        repeat (6) step(1, 0, 0, 0);
        chk("pre_l2", {2'b00, lamps}, 8'o30);
        step(0, 0, 1, 0);
        chk("preempt_on", {2'b00, lamps}, 8'o77);
        chk("preempt_mode", {6'd0, mode}, 8'd3);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("hz_on_hold", {2'b00, lamps}, 8'o77);
        end
        step(0, 0, 0, 0);
        chk("hz_off", {2'b00, lamps}, 8'o00);
        chk("hz_off_busy", {7'd0, busy}, 8'd1);

        // left & right as hazard, brake toggling has no effect.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1'(i));
            chk("lr_off", {2'b00, lamps}, 8'o00);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 1'(i));
            chk("lr_hz", {2'b00, lamps}, (i < 4) ? 8'o77 : 8'o00);
            chk("lr_mode", {6'd0, mode}, 8'd3);
        end

        // Async reset mid R2, then right held restarts at RA on the first edge.
        mid_reset("rst_c");
        repeat (6) step(0, 1, 0, 0);
        chk("pre_r2", {2'b00, lamps}, 8'o06);
        mid_reset("rst_r2");
        step(0, 1, 0, 0);
        chk("post_rst_ra", {2'b00, lamps}, 8'o04);
        chk("post_rst_mode", {6'd0, mode}, 8'd2);

        // Randomized inputs held for random stretches, with occasional mid-cycle resets.
        begin
            logic l, r, h, b;
            int hold;
            l = 0; r = 0; h = 0; b = 0; hold = 0;
            for (int i = 0; i < 1500; i++) begin
                if (hold == 0) begin
                    l = ($urandom_range(0, 2) == 0);
                    r = ($urandom_range(0, 2) == 0);
                    h = ($urandom_range(0, 7) == 0);
                    b = ($urandom_range(0, 1) == 0);
                    hold = $urandom_range(1, 14);
                end
                hold--;
                step(l, r, h, b);
                if ($urandom_range(0, 199) == 0) mid_reset("rnd_rst");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
